// File: rtl/keccak_pkg.sv
// Shared Keccak constants and the squeezer FSM state type.
package keccak_pkg;

  localparam int R_SHAKE128 = 1344;
  localparam int R_SHAKE256 = 1088;
  localparam int WORD_W     = 64;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_BLK = 2'd1,
    ST_EMIT     = 2'd2
  } sq_state_t;

endpackage

// File: rtl/squeezer_if.sv
// Bundle of request, rate-block and output-word signals around the squeezer.
interface squeezer_if
  import keccak_pkg::*;
#(
  parameter int R     = R_SHAKE128,
  parameter int LEN_W = 16
);

  logic              start;
  logic [LEN_W-1:0]  req_bytes;
  logic [R-1:0]      in;
  logic              in_ready;
  logic              in_ack;
  logic              squeeze_req;
  logic [WORD_W-1:0] out;
  logic              out_valid;
  logic              out_ack;
  logic              out_last;
  logic [2:0]        out_byte_num;
  logic              busy;
  logic              done;

  // slave: the squeezer itself; master: the user / permutation side.
  modport slave (
    input  start, req_bytes, in, in_ready, out_ack,
    output in_ack, squeeze_req, out, out_valid, out_last, out_byte_num, busy, done
  );

  modport master (
    output start, req_bytes, in, in_ready, out_ack,
    input  in_ack, squeeze_req, out, out_valid, out_last, out_byte_num, busy, done
  );

endinterface

// File: rtl/squeezer.sv
// Serializes r-bit Keccak rate blocks into 64-bit words, MSB word first,
// requesting extra permutations until the requested byte count is delivered.
module squeezer
  import keccak_pkg::*;
#(
  parameter int R     = R_SHAKE128,
  parameter int LEN_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  squeezer_if.slave  bus
);

  localparam int N_WORDS = R / WORD_W;
  localparam int WCNT_W  = $clog2(N_WORDS + 1);

  sq_state_t        state_q, state_d;
  logic [R-1:0]     sreg_q;
  logic [LEN_W-1:0] rem_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic             done_q;

  logic             capture, consume, last_word, blk_end;
  logic [LEN_W-1:0] rem_dec;

  assign capture   = (state_q == ST_WAIT_BLK) && bus.in_ready;
  assign consume   = (state_q == ST_EMIT) && bus.out_ack;
  assign last_word = (rem_q <= LEN_W'(8));
  assign rem_dec   = last_word ? rem_q : LEN_W'(8);
  assign blk_end   = (wcnt_q == WCNT_W'(N_WORDS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: always_comb gives every output a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (bus.start && (bus.req_bytes != '0)) state_d = ST_WAIT_BLK;
      ST_WAIT_BLK: if (bus.in_ready) state_d = ST_EMIT;
      ST_EMIT: begin
        if (bus.out_ack) begin
          if (last_word)    state_d = ST_IDLE;
          else if (blk_end) state_d = ST_WAIT_BLK;
        end
      end
      default:     state_d = ST_IDLE;
    endcase
  end

  // NOTE: the wide shift register is reset as well, so out reads 0 after an
  // abort and no stale rate data leaks past reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg_q <= '0;
      rem_q  <= '0;
      wcnt_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= ((state_q == ST_IDLE) && bus.start && (bus.req_bytes == '0))
              || (consume && last_word);
      if ((state_q == ST_IDLE) && bus.start) rem_q <= bus.req_bytes;
      if (capture) begin
        sreg_q <= bus.in;
        wcnt_q <= '0;
      end else if (consume) begin
        sreg_q <= sreg_q << WORD_W;
        rem_q  <= rem_q - rem_dec;
        wcnt_q <= wcnt_q + WCNT_W'(1);
      end
    end
  end

  always_comb begin
    bus.in_ack       = capture;
    bus.squeeze_req  = consume && !last_word && blk_end;
    bus.out          = sreg_q[R-1 -: WORD_W];
    bus.out_valid    = (state_q == ST_EMIT);
    bus.out_last     = (state_q == ST_EMIT) && last_word;
    bus.out_byte_num = ((state_q == ST_EMIT) && last_word) ? rem_q[2:0] : 3'd0;
    bus.busy         = (state_q != ST_IDLE);
    bus.done         = done_q;
  end

endmodule

// File: tb/tb_squeezer.sv
// Self-checking bench for squeezer: random rate blocks, byte-stream reference model.
module tb_squeezer;
  import keccak_pkg::*;

  localparam int R     = R_SHAKE128;
  localparam int LEN_W = 16;
  localparam int RB    = R / 8;      // bytes per rate block
  localparam int NW    = R / WORD_W; // words per rate block

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [R-1:0]      blks [4];
  logic [WORD_W-1:0] got_words [$];
  logic [WORD_W-1:0] ref_words [$];

  squeezer_if #(.R(R), .LEN_W(LEN_W)) bus ();

  squeezer #(.R(R), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic gen_blocks();
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < R / 32; j++)
        blks[k][32*j +: 32] = $urandom();
  endtask

  // Output byte stream = concatenation of rate blocks, each read MSB byte first.
  function automatic logic [7:0] exp_byte(input int i);
    logic [R-1:0] blk;
    blk = blks[i / RB];
    return blk[R - 1 - 8 * (i % RB) -: 8];
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_out"}, bus.out, 64'd0);
    check({tag, "_out_last"}, 64'(bus.out_last), 64'd0);
    check({tag, "_byte_num"}, 64'(bus.out_byte_num), 64'd0);
    check({tag, "_in_ack"}, 64'(bus.in_ack), 64'd0);
    check({tag, "_squeeze_req"}, 64'(bus.squeeze_req), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_done"}, 64'(bus.done), 64'd0);
  endtask

  // Runs one request of n bytes. stall_pct: chance (%) of withholding out_ack.
  // abort_at >= 0 applies reset once that many words are consumed.
  // poke_start pulses start while word 1 is being emitted.
  task automatic run_req(input int n, input int stall_pct, input int abort_at, input bit poke_start);
    int nwords, nblk, w, b, acks, sqs, dones, last_ack_cyc, done_cyc, cyc;
    bit fin, prev_valid, prev_ack, prev_in_ack, poked;
    logic [63:0] prev_out, exp_w, mask;
    logic        prev_last;
    logic [2:0]  prev_bn;
    nwords = (n + 7) / 8;
    nblk   = (n + RB - 1) / RB;
    w = 0; b = 0; acks = 0; sqs = 0; dones = 0; cyc = 0;
    last_ack_cyc = -1; done_cyc = -1;
    fin = 0; prev_valid = 0; prev_ack = 0; prev_in_ack = 0; poked = 0;
    prev_out = '0; prev_last = 0; prev_bn = '0;
    got_words.delete();

    @(negedge clk);
    bus.start = 1'b1; bus.req_bytes = LEN_W'(n);
    bus.in_ready = 1'b1; bus.in = blks[0]; bus.out_ack = 1'b0;

    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      if (poke_start && w == 1 && !poked) begin
        bus.start = 1'b1; bus.req_bytes = LEN_W'(5); poked = 1;
      end
      bus.in = blks[b];
      bus.out_ack = ($urandom_range(99) >= stall_pct);

      if (abort_at >= 0 && w == abort_at) begin
        reset = 1'b0;
        #1;
        check_idle_outputs("abort");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          #1;
          check("post_abort_valid", 64'(bus.out_valid), 64'd0);
          check("post_abort_done", 64'(bus.done), 64'd0);
          check("post_abort_in_ack", 64'(bus.in_ack), 64'd0);
        end
        bus.out_ack = 1'b0; bus.in_ready = 1'b0;
        return;
      end

      #1;
      if (prev_in_ack) check("valid_after_capture", 64'(bus.out_valid), 64'd1);
      if (prev_valid && !prev_ack && bus.out_valid) begin
        check("stall_out", bus.out, prev_out);
        check("stall_last", 64'(bus.out_last), 64'(prev_last));
        check("stall_bn", 64'(bus.out_byte_num), 64'(prev_bn));
      end
      if (bus.in_ack) begin acks++; b++; end
      if (bus.squeeze_req) sqs++;
      if (bus.done) begin dones++; done_cyc = cyc; fin = 1; end
      if (bus.out_valid && bus.out_ack) begin
        exp_w = '0; mask = '0;
        for (int k = 0; k < 8; k++)
          if (8 * w + k < n) begin
            exp_w[63 - 8*k -: 8] = exp_byte(8 * w + k);
            mask[63 - 8*k -: 8]  = 8'hFF;
          end
        check("word", bus.out & mask, exp_w);
        check("out_last", 64'(bus.out_last), 64'(w == nwords - 1));
        check("byte_num", 64'(bus.out_byte_num), (w == nwords - 1) ? 64'(n % 8) : 64'd0);
        got_words.push_back(bus.out & mask);
        last_ack_cyc = cyc;
        w++;
      end
      prev_valid = bus.out_valid; prev_ack = bus.out_ack; prev_in_ack = bus.in_ack;
      prev_out = bus.out; prev_last = bus.out_last; prev_bn = bus.out_byte_num;
    end

    check("timeout", 64'(fin), 64'd1);
    check("word_count", 64'(w), 64'(nwords));
    check("in_ack_count", 64'(acks), 64'(nblk));
    check("squeeze_count", 64'(sqs), 64'(nblk - 1));
    check("done_count", 64'(dones), 64'd1);
    check("done_latency", 64'(done_cyc - last_ack_cyc), 64'd1);
    @(negedge clk);
    bus.out_ack = 1'b0; bus.in_ready = 1'b0;
    #1;
    check("done_pulse_end", 64'(bus.done), 64'd0);
    check("idle_after", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    reset = 1'b0;
    bus.start = 1'b0; bus.req_bytes = '0; bus.in = '0;
    bus.in_ready = 1'b0; bus.out_ack = 1'b0;
    gen_blocks();
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b1;

    // One block, 4 full words; 2 words with a 5-byte tail.
    run_req(32, 0, -1, 0);
    run_req(13, 0, -1, 0);

    // Exact block boundary vs. crossing into a second block.
    gen_blocks();
    run_req(168, 0, -1, 0);
    run_req(170, 0, -1, 0);

    // Backpressure: stalled run must match the unstalled one; start mid-EMIT ignored.
    gen_blocks();
    run_req(40, 0, -1, 0);
    ref_words = got_words;
    run_req(40, 60, -1, 1);
    check("stall_len", 64'(got_words.size()), 64'(ref_words.size()));
    for (int i = 0; i < ref_words.size() && i < got_words.size(); i++)
      check("stall_seq", got_words[i], ref_words[i]);

    // Zero-length request: done only, nothing captured or emitted.
    @(negedge clk);
    bus.start = 1'b1; bus.req_bytes = '0; bus.in_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    check("zero_done", 64'(bus.done), 64'd1);
    check("zero_valid", 64'(bus.out_valid), 64'd0);
    check("zero_in_ack", 64'(bus.in_ack), 64'd0);
    check("zero_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    #1;
    check("zero_done_end", 64'(bus.done), 64'd0);
    check("zero_valid2", 64'(bus.out_valid), 64'd0);
    check("zero_in_ack2", 64'(bus.in_ack), 64'd0);
    bus.in_ready = 1'b0;

    // Reset during a 21-word request, then a fresh 16-byte request.
    gen_blocks();
    run_req(168, 0, 3, 0);
    gen_blocks();
    run_req(16, 0, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/squeezer.md
Name: squeezer

Overview:
- Output-side counterpart of the absorb padder: takes r-bit rate blocks from the f_permutation module and serializes them into 64-bit words for the user.
- Delivers exactly the requested number of bytes, marking the final word with out_last and out_byte_num.
- Requests further permutations (squeeze_req) when the requested length exceeds one rate block, as needed for SHAKE128/256 XOF output in Kyber.

Parameters:
- r, 1344, bitrate in bits; must be a multiple of 64 (1344 = SHAKE128, 1088 = SHAKE256).
- LEN_W, 16, width of the requested byte count.
- N_WORDS, r/64, words per rate block; localparam, derived.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; latches req_bytes; ignored unless idle
- req_bytes  input  LEN_W  number of output bytes requested
- in  input  r  rate portion of the Keccak state, from f_permutation
- in_ready  input  1  f_permutation holds a valid block on in
- in_ack  output  1  one-cycle pulse: block captured
- squeeze_req  output  1  one-cycle pulse: permute again
- out  output  64  output word
- out_valid  output  1  out holds a valid word
- out_ack  input  1  user consumes the word when out_valid is 1
- out_last  output  1  current word is the final one
- out_byte_num  output  3  valid bytes in the final word; 0 encodes 8; 0 when out_last is 0
- busy  output  1  high whenever not IDLE
- done  output  1  one-cycle pulse when the request completes

Behaviour:
- Reset (asynchronous, active-low): all outputs 0, FSM to IDLE, shift register and counters cleared. Reset asserted mid-operation aborts the request: no done pulse, and no partial words after reset release.
- Registers:
  - sreg[r-1:0]: shift register.
  - rem[LEN_W-1:0]: bytes still to emit.
  - wcnt: words emitted from the current block, 0..N_WORDS.
- FSM states: IDLE, WAIT_BLK, EMIT.
- IDLE:
  - start with req_bytes == 0: pulse done next cycle, stay IDLE.
  - start with req_bytes > 0: rem <= req_bytes, go to WAIT_BLK.
- WAIT_BLK, when in_ready == 1:
  - sreg <= in, wcnt <= 0, pulse in_ack (same cycle as capture), go to EMIT.
  - out_valid rises in the cycle after capture.
- EMIT:
  - out = sreg[r-1 -: 64]; the first word comes from the MSBs, matching the absorb ordering.
  - out_valid = 1. out_last = (rem <= 8). out_byte_num = rem[2:0] when out_last is 1, else 0.
  - On out_ack: sreg shifts left 64, rem <= rem - min(rem, 8), wcnt increments. Then:
    - (a) rem reaches 0: out_valid drops, pulse done, go to IDLE.
    - (b) else wcnt reaches N_WORDS: pulse squeeze_req, go to WAIT_BLK.
    - (c) else stay in EMIT; the next word is presented on the following cycle. Throughput is 1 word/cycle under continuous out_ack.
- out, out_last and out_byte_num are held stable while out_valid is 1 and out_ack is 0. out_ack while out_valid is 0 is ignored.
- A block already present when WAIT_BLK is entered is captured on the first cycle of WAIT_BLK.
- in_ready while not in WAIT_BLK is ignored, and no in_ack is issued.
- start while busy is ignored.
- No squeeze_req is issued after the final word, even if it falls exactly on a block boundary.
- Unused bytes of the last word are don't-care. The bench checks only the first out_byte_num bytes, counted from the MSB byte.

Decomposition:
- Shared package keccak_pkg holds:
  - rate constants R_SHAKE128 = 1344 and R_SHAKE256 = 1088;
  - word width constant 64;
  - the squeezer state enum.
- No sub-module. The min(rem, 8) subtract and the last-word decode stay inline.

Test Plan:
- req_bytes = 32, one block → 4 words. out_last only on word 4, with out_byte_num = 0; done 1 cycle after the 4th out_ack; no squeeze_req.
- req_bytes = 13 → 2 words. Word 2 has out_last = 1 and out_byte_num = 5; words equal in[1343:1280] and in[1279:1216].
- req_bytes = 168 → 21 words, no squeeze_req, done. req_bytes = 170 → 21 words, squeeze_req pulse, in_ack on second block, 1 word with out_byte_num = 2.
- Random out_ack backpressure on a 40-byte request: out stable while stalled; word sequence identical to the no-stall run; in_ack exactly once.
- req_bytes = 0 → done pulse, out_valid never asserted, in_ack never asserted. start during EMIT → ignored.
- reset low mid-EMIT (after word 3 of 21) → all outputs 0 immediately, FSM in IDLE. A new 16-byte request then produces 2 correct words.
